// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//
// Read-side consumer for the register-based shift FIFO. It pops words from the
// FIFO head cell via shift_out/fifo_empty_n and presents them downstream on a
// registered valid/ready interface. A 2-entry skid buffer keeps one word per
// cycle flowing under back-pressure. A flush request drains and discards
// everything buffered here and everything still queued in the FIFO.
//
// Optional feature: define FIFO_READER_COUNT_EN to add the word_cnt port, a
// wrapping count of words delivered downstream (flushed words not counted).
//
// Parameters:
//   WIDTH      data word width (same as the FIFO's WIDTH)
//   CNT_WIDTH  delivered-word counter width (only with FIFO_READER_COUNT_EN)
//
// Ports:
//   clk           in   clock, rising edge
//   res_n         in   asynchronous active-low reset
//   fifo_data     in   FIFO head word
//   fifo_empty_n  in   FIFO head cell holds valid data
//   shift_out     out  pop request; head word consumed at this rising edge
//   dout          out  downstream data (registered)
//   dout_valid    out  dout holds a word
//   dout_ready    in   downstream accepts the word this cycle
//   flush         in   single-cycle request to discard all words
//   flush_done    out  one-cycle pulse in the final flush cycle
//   word_cnt      out  delivered-word count (only with FIFO_READER_COUNT_EN)
// -----------------------------------------------------------------------------
module fifo_reader #(
    parameter int WIDTH = 4
`ifdef FIFO_READER_COUNT_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty_n,
    output logic             shift_out,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    input  logic             flush,
    output logic             flush_done
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] word_cnt
`endif
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic             xfer;

    // Outputs depend only on registered state plus fifo_empty_n; shift_out
    // deliberately ignores dout_ready so there is no ready->pop combinational
    // path. Gating with res_n keeps the FIFO from being popped during reset.
    always_comb begin
        dout       = buf0_q;
        dout_valid = (state_q == ST_RUN) && (count_q != 2'd0);
        xfer       = dout_valid && dout_ready;
        if (state_q == ST_FLUSH) begin
            shift_out = res_n && fifo_empty_n;
        end else begin
            shift_out = res_n && fifo_empty_n && (count_q != 2'd2);
        end
        // Asserted in the cycle that observes the FIFO empty; the FSM leaves
        // FLUSH at the end of this same cycle, so the pulse is one cycle wide.
        flush_done = (state_q == ST_FLUSH) && !fifo_empty_n;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    // A same-cycle transfer still completes (counted below);
                    // remaining entries and any word popped now are dropped.
                    state_d = ST_FLUSH;
                    count_d = 2'd0;
                end else begin
                    case ({shift_out, xfer})
                        2'b10: begin
                            if (count_q == 2'd0) buf0_d = fifo_data;
                            else                 buf1_d = fifo_data;
                            count_d = count_q + 2'd1;
                        end
                        2'b01: begin
                            buf0_d  = buf1_q;
                            count_d = count_q - 2'd1;
                        end
                        2'b11: begin
                            // Occupancy unchanged: the new word lands in the
                            // entry freed by the shift, preserving order.
                            if (count_q == 2'd1) begin
                                buf0_d = fifo_data;
                            end else begin
                                buf0_d = buf1_q;
                                buf1_d = fifo_data;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_FLUSH: begin
                if (!fifo_empty_n) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_RUN;
            count_q <= 2'd0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
        end
    end

`ifdef FIFO_READER_COUNT_EN
    logic [CNT_WIDTH-1:0] word_cnt_q;

    // Wraps naturally at 2^CNT_WIDTH; flush never clears it.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            word_cnt_q <= '0;
        end else if (xfer) begin
            word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

    logic       clk;
    logic       res_n;
    logic [3:0] fifo_data;
    logic       fifo_empty_n;
    logic       shift_out;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       flush;
    logic       flush_done;
`ifdef FIFO_READER_COUNT_EN
    logic [15:0] word_cnt;
    logic [15:0] cnt_snap;
`endif

    // FIFO source: circular array, head advanced by the DUT's pops
    logic [3:0] mem [64];
    int head = 0;
    int tail = 0;
    assign fifo_data    = mem[head[5:0]];
    assign fifo_empty_n = (head != tail);

    fifo_reader #(.WIDTH(4)) dut (
        .clk         (clk),
        .res_n       (res_n),
        .fifo_data   (fifo_data),
        .fifo_empty_n(fifo_empty_n),
        .shift_out   (shift_out),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .flush       (flush),
        .flush_done  (flush_done)
`ifdef FIFO_READER_COUNT_EN
        ,
        .word_cnt    (word_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: list of words held by the reader, flush flag, count
    logic [3:0]  mq[$];
    bit          m_flush = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    bit          m_ne;

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            mq.delete();
            m_flush = 1'b0;
            m_cnt   = 16'd0;
            head   <= tail;
        end else begin
            m_ne = (head != tail);
            if (shift_out) head <= head + 1;
            if (m_flush) begin
                if (!m_ne) m_flush = 1'b0;
            end else begin
                bit take;
                take = m_ne && (mq.size() < 2);
                if (mq.size() > 0 && dout_ready) begin
                    void'(mq.pop_front());
                    m_cnt = m_cnt + 16'd1;
                end
                if (flush) begin
                    mq.delete();
                    m_flush = 1'b1;
                end else if (take) begin
                    mq.push_back(fifo_data);
                end
            end
        end
    end

    // Compare process plus event recording for the directed checks
    int tick = 0;
    int pops = 0;
    int fd_cnt = 0;
    int fd_t = 0;
    int fl_t = 0;
    int vld_cnt = 0;
    int first_pop_t = -1;
    logic [3:0] got[$];
    int got_t[$];

    always @(negedge clk) begin
        tick++;
        if (res_n) begin
            bit ne, ev, ep, ef;
            ne = (head != tail);
            ev = !m_flush && (mq.size() > 0);
            ep = m_flush ? ne : (ne && (mq.size() < 2));
            ef = m_flush && !ne;
            chk("shift_out", {31'd0, shift_out}, {31'd0, ep});
            chk("dout_valid", {31'd0, dout_valid}, {31'd0, ev});
            chk("flush_done", {31'd0, flush_done}, {31'd0, ef});
            if (ev) chk("dout", {28'd0, dout}, {28'd0, mq[0]});
`ifdef FIFO_READER_COUNT_EN
            chk("word_cnt", {16'd0, word_cnt}, {16'd0, m_cnt});
`endif
            if (shift_out) begin
                pops++;
                if (first_pop_t < 0) first_pop_t = tick;
            end
            if (flush_done) begin
                fd_cnt++;
                fd_t = tick;
            end
            if (flush) fl_t = tick;
            if (dout_valid) vld_cnt++;
            if (dout_valid && dout_ready) begin
                got.push_back(dout);
                got_t.push_back(tick);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [3:0] v);
        mem[tail[5:0]] = v;
        tail = tail + 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dout"}, {28'd0, dout}, 32'd0);
        chk({tag, "_dout_valid"}, {31'd0, dout_valid}, 32'd0);
        chk({tag, "_shift_out"}, {31'd0, shift_out}, 32'd0);
        chk({tag, "_flush_done"}, {31'd0, flush_done}, 32'd0);
`ifdef FIFO_READER_COUNT_EN
        chk({tag, "_word_cnt"}, {16'd0, word_cnt}, 32'd0);
`endif
    endtask

    initial begin
        int pb, fdb, vb;
        res_n      = 1'b1;
        dout_ready = 1'b0;
        flush      = 1'b0;
        #1 res_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) cyc();
        res_n = 1'b1;
        repeat (3) cyc();
        check_reset_outputs("idle");

        // Streaming 1..4 with ready high
        got.delete(); got_t.delete();
        first_pop_t = -1;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        dout_ready = 1'b1;
        repeat (8) cyc();
        chk("stream_n", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                chk("stream_word", {28'd0, got[i]}, i + 1);
                chk("stream_gapless", got_t[i] - got_t[0], i);
            end
        end
        if (got.size() > 0) chk("stream_latency", got_t[0] - first_pop_t, 1);
`ifdef FIFO_READER_COUNT_EN
        chk("stream_cnt", {16'd0, word_cnt}, 4);
`endif

        // Back-pressure 5,6,7
        dout_ready = 1'b0;
        pb = pops;
        push(4'h5); push(4'h6); push(4'h7);
        repeat (5) cyc();
        chk("bp_pops", pops - pb, 2);
        chk("bp_shift_low", {31'd0, shift_out}, 0);
        chk("bp_dout", {28'd0, dout}, 4'h5);
        chk("bp_valid", {31'd0, dout_valid}, 1);
        got.delete(); got_t.delete();
        dout_ready = 1'b1;
        repeat (6) cyc();
        chk("bp_n", got.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                chk("bp_word", {28'd0, got[i]}, i + 5);
                chk("bp_gapless", got_t[i] - got_t[0], i);
            end
        end

        // Flush with 0xA,0xB buffered and 3 words queued
        dout_ready = 1'b0;
        push(4'hA); push(4'hB);
        repeat (4) cyc();
        push(4'hC); push(4'hD); push(4'hE);
        cyc();
`ifdef FIFO_READER_COUNT_EN
        cnt_snap = m_cnt;
`endif
        pb  = pops;
        fdb = fd_cnt;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        vb = vld_cnt;
        repeat (8) cyc();
        chk("flush_pops", pops - pb, 3);
        chk("flush_done_once", fd_cnt - fdb, 1);
        chk("flush_duration", fd_t - fl_t, 4);
        chk("flush_no_valid", vld_cnt - vb, 0);
        chk("flush_after_valid", {31'd0, dout_valid}, 0);
`ifdef FIFO_READER_COUNT_EN
        chk("flush_cnt_kept", {16'd0, word_cnt}, {16'd0, cnt_snap});
`endif
        got.delete(); got_t.delete();
        dout_ready = 1'b1;
        push(4'h9);
        repeat (3) cyc();
        chk("run_again_n", got.size(), 1);
        if (got.size() > 0) chk("run_again_word", {28'd0, got[0]}, 4'h9);

        // Flush with FIFO already empty
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        repeat (3) cyc();
        chk("flush_empty_duration", fd_t - fl_t, 1);

        // Flush in the same cycle as a completing transfer
        got.delete(); got_t.delete();
        push(4'h1); push(4'h2); push(4'h3);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        repeat (5) cyc();
        chk("flush_xfer_n", got.size(), 1);
        if (got.size() > 0) chk("flush_xfer_word", {28'd0, got[0]}, 1);
        chk("flush_xfer_duration", fd_t - fl_t, 2);

`ifdef FIFO_READER_COUNT_EN
        // Counter wrap
        begin
            int need;
            need = 65535 - int'(m_cnt);
            for (int i = 0; i < need; i++) begin
                push(i[3:0]);
                cyc();
            end
            repeat (4) cyc();
            chk("cnt_max", {16'd0, word_cnt}, 32'h0000FFFF);
            push(4'h3);
            repeat (3) cyc();
            chk("cnt_wrap", {16'd0, word_cnt}, 0);
        end
`endif

        // Reset mid-stream with count = 2
        dout_ready = 1'b0;
        push(4'h1); push(4'h2); push(4'h3);
        repeat (4) cyc();
        chk("pre_reset_valid", {31'd0, dout_valid}, 1);
        res_n = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (2) cyc();
        res_n = 1'b1;
        repeat (3) cyc();
        chk("post_reset_valid", {31'd0, dout_valid}, 0);
        chk("post_reset_dout", {28'd0, dout}, 0);
        got.delete(); got_t.delete();
        dout_ready = 1'b1;
        push(4'hC);
        repeat (3) cyc();
        chk("post_reset_n", got.size(), 1);
        if (got.size() > 0) chk("post_reset_word", {28'd0, got[0]}, 4'hC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
